alu_cmd_sequencer: RTL and testbench

Sequential front-end that drives the team's combinational 3-bit ALU (ADD/SUB/SHL, CF/SF/ZF flags).
- Accepts operation commands over a valid/ready handshake and issues them to the ALU's A/B/OP inputs.
- Captures R and flags, then returns them over a result valid/ready handshake.
- Adds a multi-cycle MUL command, built from repeated ALU additions.

---
 rtl/alu_cmd_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Sequential front-end for the shared combinational 3-bit ALU (ADD/SUB/SHL with CF/SF/ZF).
// A command is accepted over a valid/ready handshake and issued to the ALU. The result and
// flags are captured and returned over a second valid/ready handshake. The MUL command is
// built from repeated ALU additions: the accumulator is added to A once per step, B times.
//
// Optional build macro:
//   ALU_SEQ_B2B_EN - when defined, cmd_ready follows res_ready in DONE, so a result can be
//                    retired and a new command accepted in the same cycle (no idle bubble).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op, cmd_a, cmd_b            00 ADD, 01 SUB, 10 SHL, 11 MUL; operands
//   alu_a, alu_b, alu_op            drive to the ALU (op 11 = ALU idle)
//   alu_r, alu_cf, alu_sf, alu_zf   combinational ALU result and flags
//   res_valid/res_ready             result handshake
//   res_r, res_cf, res_sf, res_zf   registered result and flags

module alu_cmd_sequencer #(
    parameter int unsigned W  = 3,
    parameter int unsigned CW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_r,
    input  logic         alu_cf,
    input  logic         alu_sf,
    input  logic         alu_zf,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_r,
    output logic         res_cf,
    output logic         res_sf,
    output logic         res_zf
);

    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpMul  = 2'b11;
    localparam logic [1:0] OpIdle = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMulLoop,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cf_sticky_q, cf_sticky_d;
    logic [W-1:0]    res_r_q, res_r_d;
    logic            res_cf_q, res_cf_d;
    logic            res_sf_q, res_sf_d;
    logic            res_zf_q, res_zf_d;

    logic            cmd_fire;

    assign cmd_fire = cmd_valid & cmd_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            cf_sticky_q <= 1'b0;
            res_r_q     <= '0;
            res_cf_q    <= 1'b0;
            res_sf_q    <= 1'b0;
            res_zf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cf_sticky_q <= cf_sticky_d;
            res_r_q     <= res_r_d;
            res_cf_q    <= res_cf_d;
            res_sf_q    <= res_sf_d;
            res_zf_q    <= res_zf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cf_sticky_d = cf_sticky_q;
        res_r_d     = res_r_q;
        res_cf_d    = res_cf_q;
        res_sf_d    = res_sf_q;
        res_zf_d    = res_zf_q;

        unique case (state_q)
            StIdle: begin
                // Command acceptance is handled below, shared with DONE.
            end
            StExec: begin
                res_r_d  = alu_r;
                res_cf_d = alu_cf;
                res_sf_d = alu_sf;
                res_zf_d = alu_zf;
                state_d  = StDone;
            end
            StMulLoop: begin
                acc_d       = alu_r;
                cf_sticky_d = cf_sticky_q | alu_cf;
                cnt_d       = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Any carry along the way means the product overflowed W bits.
                    res_r_d  = alu_r;
                    res_cf_d = cf_sticky_q | alu_cf;
                    res_sf_d = alu_r[W-1];
                    res_zf_d = (alu_r == '0);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // cmd_ready is only high in IDLE, or in DONE with res_ready when back-to-back is
        // enabled, so a fire here always overrides the DONE -> IDLE transition cleanly.
        if (cmd_fire) begin
            op_d = cmd_op;
            a_d  = cmd_a;
            b_d  = cmd_b;
            if (cmd_op != OpMul) begin
                state_d = StExec;
            end else if (cmd_b != '0) begin
                acc_d       = '0;
                cnt_d       = CW'(cmd_b);
                cf_sticky_d = 1'b0;
                state_d     = StMulLoop;
            end else begin
                res_r_d  = '0;
                res_cf_d = 1'b0;
                res_sf_d = 1'b0;
                res_zf_d = 1'b1;
                state_d  = StDone;
            end
        end
    end

    // Output logic
    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = OpIdle;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
            end
            StExec: begin
                alu_a  = a_q;
                alu_b  = b_q;
                alu_op = op_q;
            end
            StMulLoop: begin
                alu_a  = acc_q;
                alu_b  = a_q;
                alu_op = OpAdd;
            end
            StDone: begin
                res_valid = 1'b1;
`ifdef ALU_SEQ_B2B_EN
                cmd_ready = res_ready;
`else
                cmd_ready = 1'b0;
`endif
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign res_r  = res_r_q;
    assign res_cf = res_cf_q;
    assign res_sf = res_sf_q;
    assign res_zf = res_zf_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//
// Self-checking bench for alu_cmd_sequencer. Provides a behavioural 3-bit ALU on the DUT's
// ALU port, runs directed and random commands, and compares results, flags, ALU drive and
// latency against an arithmetic reference model. Honours ALU_SEQ_B2B_EN if defined.

module tb_alu_cmd_sequencer;

    localparam int W  = 3;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_r;
    logic         alu_cf;
    logic         alu_sf;
    logic         alu_zf;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_r;
    logic         res_cf;
    logic         res_sf;
    logic         res_zf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .W (W),
        .CW(CW)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_r    (alu_r),
        .alu_cf   (alu_cf),
        .alu_sf   (alu_sf),
        .alu_zf   (alu_zf),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_r    (res_r),
        .res_cf   (res_cf),
        .res_sf   (res_sf),
        .res_zf   (res_zf)
    );

    // Behavioural ALU: ADD carry-out, SUB borrow, SHL any bit shifted out.
    int alu_full;
    always_comb begin
        alu_full = 0;
        alu_cf   = 1'b0;
        case (alu_op)
            2'b00: begin
                alu_full = int'(alu_a) + int'(alu_b);
                alu_cf   = (alu_full > 7);
            end
            2'b01: begin
                alu_full = int'(alu_a) - int'(alu_b) + 8;
                alu_cf   = (alu_a < alu_b);
            end
            2'b10: begin
                alu_full = int'(alu_a) << alu_b;
                alu_cf   = (alu_full > 7);
            end
            default: alu_full = 0;
        endcase
        alu_r  = 3'(alu_full);
        alu_sf = alu_r[2];
        alu_zf = (alu_r == 3'd0);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference result packed as {cf, sf, zf, r[2:0]}.
    function automatic logic [5:0] expect_res(input int op, input int a, input int b);
        int p;
        int r;
        int cf;
        case (op)
            0: begin p = a + b;        r = p % 8;           cf = int'(p > 7); end
            1: begin                   r = (a - b + 8) % 8; cf = int'(a < b); end
            2: begin p = a * (2 ** b); r = p % 8;           cf = int'(p > 7); end
            default: begin p = a * b; r = p % 8;            cf = int'(p > 7); end
        endcase
        return {1'(cf), 1'(r >= 4), 1'(r == 0), 3'(r)};
    endfunction

    task automatic scramble_cmd();
        cmd_op    = 2'($urandom);
        cmd_a     = 3'($urandom);
        cmd_b     = 3'($urandom);
        cmd_valid = 1'($urandom);
    endtask

    // Issue one command from IDLE, check ALU drive each busy cycle, latency (edges counted
    // from the accepting edge inclusive), a held result, then retire it.
    task automatic run_cmd(input int op, input int a, input int b, input int hold);
        logic [5:0] e;
        int edges;
        int step;
        int lat;
        e = expect_res(op, a, b);
        lat = (op == 3) ? b + 1 : 2;
        @(negedge clk);
        check_eq("cmd_ready_idle", int'(cmd_ready), 1);
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_a     = 3'(a);
        cmd_b     = 3'(b);
        @(posedge clk);
        edges = 1;
        step  = 0;
        @(negedge clk);
        scramble_cmd();
        while (!res_valid && edges < 20) begin
            if (op == 3) begin
                check_eq("mul_alu_op", int'(alu_op), 0);
                check_eq("mul_alu_a", int'(alu_a), (step * a) % 8);
                check_eq("mul_alu_b", int'(alu_b), a);
                step++;
            end else begin
                check_eq("exec_alu_op", int'(alu_op), op);
                check_eq("exec_alu_a", int'(alu_a), a);
                check_eq("exec_alu_b", int'(alu_b), b);
            end
            check_eq("busy_cmd_ready", int'(cmd_ready), 0);
            @(posedge clk);
            edges++;
            @(negedge clk);
            scramble_cmd();
        end
        check_eq("latency", edges, lat);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(posedge clk);
                @(negedge clk);
                scramble_cmd();
            end
            check_eq("res_valid", int'(res_valid), 1);
            check_eq("res_r", int'(res_r), int'(e[2:0]));
            check_eq("res_cf", int'(res_cf), int'(e[5]));
            check_eq("res_sf", int'(res_sf), int'(e[4]));
            check_eq("res_zf", int'(res_zf), int'(e[3]));
            check_eq("done_cmd_ready", int'(cmd_ready), 0);
            check_eq("done_alu_op", int'(alu_op), 3);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("retired_res_valid", int'(res_valid), 0);
        check_eq("retired_cmd_ready", int'(cmd_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b0;
        #1;
        check_eq("rst_res_valid", int'(res_valid), 0);
        check_eq("rst_res_r", int'(res_r), 0);
        check_eq("rst_res_zf", int'(res_zf), 0);
        check_eq("rst_alu_op", int'(alu_op), 3);
        check_eq("rst_alu_a", int'(alu_a), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_cmd(0, 3, 5, 0);
        run_cmd(1, 2, 3, 1);
        run_cmd(3, 3, 3, 0);
        run_cmd(3, 0, 5, 0);
        run_cmd(3, 5, 0, 2);
        run_cmd(2, 3, 1, 5);

        // Reset in the third MUL_LOOP cycle
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_a     = 3'd7;
        cmd_b     = 3'd7;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("mul3_alu_a", int'(alu_a), 6);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_alu_op", int'(alu_op), 3);
        check_eq("midrst_alu_a", int'(alu_a), 0);
        check_eq("midrst_alu_b", int'(alu_b), 0);
        check_eq("midrst_res_valid", int'(res_valid), 0);
        check_eq("midrst_res_r", int'(res_r), 0);
        check_eq("midrst_res_cf", int'(res_cf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("postrst_no_result", int'(res_valid), 0);
        end
        run_cmd(0, 1, 1, 0);

        // Random commands
        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

`ifdef ALU_SEQ_B2B_EN
        // Back-to-back ADDs with both handshakes held open: one result every 2 cycles.
        begin
            int exp_q[$];
            int issued;
            int seen;
            int last_cyc;
            int a;
            int b;
            issued   = 0;
            seen     = 0;
            last_cyc = -1;
            res_ready = 1'b1;
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk);
                if (res_valid) begin
                    if (exp_q.size() > 0) begin
                        check_eq("b2b_res_r", int'(res_r), exp_q.pop_front());
                    end else begin
                        check_eq("b2b_unexpected_result", 1, 0);
                    end
                    if (last_cyc >= 0) check_eq("b2b_gap", cyc - last_cyc, 2);
                    last_cyc = cyc;
                    seen++;
                end
                if (cmd_ready && issued < 8) begin
                    a = int'($urandom_range(0, 7));
                    b = int'($urandom_range(0, 7));
                    cmd_valid = 1'b1;
                    cmd_op    = 2'b00;
                    cmd_a     = 3'(a);
                    cmd_b     = 3'(b);
                    exp_q.push_back((a + b) % 8);
                    issued++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            check_eq("b2b_count", seen, 8);
            res_ready = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
